// File: rtl/ldpc_pkg.sv
// Shared types and constants for the LDPC iteration controller and decoder datapath.
package ldpc_pkg;

  localparam int unsigned N_VARS           = 10;
  localparam int unsigned N_CHECKS         = 5;
  localparam int unsigned LLR_W            = 32;
  localparam int unsigned DEFAULT_MAX_ITER = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_V2C,
    ST_C2V,
    ST_BEL,
    ST_CHK,
    ST_DONE
  } ldpc_ctrl_state_t;

endpackage

// File: rtl/ldpc_sat_counter.sv
// Up-counter that increments on inc and holds at all-ones instead of wrapping.
module ldpc_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration scheduler: sequences LOAD/V2C/C2V/BEL/CHK per frame with early exit.
// Define LDPC_ITER_STATS_EN to add saturating frame_cnt/fail_cnt outputs.
module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int unsigned MAX_ITER = DEFAULT_MAX_ITER,
  parameter int unsigned ITER_W   = 4,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              syndrome_ok,
  output logic              ld_en,
  output logic              v2c_en,
  output logic              c2v_en,
  output logic              bel_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy
`ifdef LDPC_ITER_STATS_EN
  ,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] fail_cnt
`endif
);

  localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

  ldpc_ctrl_state_t  state_q, state_d;
  logic [ITER_W-1:0] iter_count_q, iter_count_d;
  logic              converged_q, converged_d;
  logic              in_ready_q, in_ready_d;
  logic              ld_en_q, ld_en_d;
  logic              v2c_en_q, v2c_en_d;
  logic              c2v_en_q, c2v_en_d;
  logic              bel_en_q, bel_en_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      iter_count_q <= '0;
      converged_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      ld_en_q      <= 1'b0;
      v2c_en_q     <= 1'b0;
      c2v_en_q     <= 1'b0;
      bel_en_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_count_q <= iter_count_d;
      converged_q  <= converged_d;
      in_ready_q   <= in_ready_d;
      ld_en_q      <= ld_en_d;
      v2c_en_q     <= v2c_en_d;
      c2v_en_q     <= c2v_en_d;
      bel_en_q     <= bel_en_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  // iter_count/converged are left untouched by flush so the last frame stays visible.
  always_comb begin
    state_d      = state_q;
    iter_count_d = iter_count_q;
    converged_d  = converged_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid && in_ready_q) begin
          state_d      = ST_LOAD;
          iter_count_d = '0;
          converged_d  = 1'b0;
        end
        ST_LOAD: state_d = ST_V2C;
        ST_V2C:  state_d = ST_C2V;
        ST_C2V:  state_d = ST_BEL;
        ST_BEL: begin
          state_d      = ST_CHK;
          iter_count_d = iter_count_q + 1'b1;
        end
        ST_CHK: begin
          if (syndrome_ok) begin
            state_d     = ST_DONE;
            converged_d = 1'b1;
          end else if (iter_count_q == MAX_ITER_C) begin
            state_d     = ST_DONE;
            converged_d = 1'b0;
          end else begin
            state_d = ST_V2C;
          end
        end
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so each registered enable lines up with its state.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    ld_en_d     = (state_d == ST_LOAD);
    v2c_en_d    = (state_d == ST_V2C);
    c2v_en_d    = (state_d == ST_C2V);
    bel_en_d    = (state_d == ST_BEL);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign in_ready   = in_ready_q;
  assign ld_en      = ld_en_q;
  assign v2c_en     = v2c_en_q;
  assign c2v_en     = c2v_en_q;
  assign bel_en     = bel_en_q;
  assign out_valid  = out_valid_q;
  assign converged  = converged_q;
  assign iter_count = iter_count_q;
  assign busy       = busy_q;

`ifdef LDPC_ITER_STATS_EN
  logic handshake;
  assign handshake = (state_q == ST_DONE) && out_ready && !flush;

  ldpc_sat_counter #(.WIDTH(STAT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handshake),
    .count (frame_cnt)
  );

  ldpc_sat_counter #(.WIDTH(STAT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handshake && !converged_q),
    .count (fail_cnt)
  );
`endif

endmodule

// File: doc/ldpc_iter_ctrl.md
Name: ldpc_iter_ctrl

Overview:
- Iteration scheduler for the LDPC decoder datapath (variable-to-check, check-to-variable, belief/hard-decision stages).
- Accepts one frame of channel evidence per valid/ready handshake and sequences the phases LOAD, V2C, C2V, BEL and CHK.
- Terminates early when the datapath reports a zero syndrome, otherwise after MAX_ITER iterations.
- Presents the result through a valid/ready output handshake; drives phase enables only, holds no LLR data.

Parameters:
- MAX_ITER, 8, maximum decoding iterations per frame (>=1).
- ITER_W, 4, width of iteration counter; must hold MAX_ITER.
- STAT_W, 16, width of statistics counters (STATS_EN only).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a frame of channel evidence is presented to the datapath.
- in_ready  output  1  controller can accept a frame.
- flush  input  1  synchronous abort of the current frame.
- syndrome_ok  input  1  datapath parity check result: all checks satisfied by corrected_seq.
- ld_en  output  1  datapath captures channelEvidence into channelBelief and message registers.
- v2c_en  output  1  variable-to-check message update.
- c2v_en  output  1  check-to-variable message update.
- bel_en  output  1  belief and corrected-bit update.
- out_valid  output  1  corrected_seq is final.
- out_ready  input  1  downstream consumes the result.
- converged  output  1  the result passed the syndrome check.
- iter_count  output  ITER_W  completed iterations for the current/last frame.
- busy  output  1  state != IDLE.

Behaviour:
- All outputs are registered. Reset (async, rst_n=0): state=IDLE, in_ready=0, all enables=0, out_valid=0, converged=0, iter_count=0, busy=0.
- in_ready goes 1 on the first clk edge after reset release.
- FSM states: IDLE, LOAD, V2C, C2V, BEL, CHK, DONE. Each of LOAD/V2C/C2V/BEL lasts exactly one cycle, with its enable high only in that cycle.
- IDLE: in_ready=1. On in_valid&&in_ready: go to LOAD, in_ready->0, iter_count->0, converged->0.
- LOAD->V2C->C2V->BEL->CHK unconditionally.
- CHK: syndrome_ok is sampled only here and ignored in every other state. iter_count increments on entry to CHK.
  - If syndrome_ok: go to DONE with converged=1.
  - Else if iter_count==MAX_ITER: go to DONE with converged=0.
  - Else: go to V2C.
- DONE: out_valid=1. out_valid, converged and iter_count are held stable until out_ready. On out_valid&&out_ready go to IDLE with in_ready=1 next cycle; no back-to-back accept in the same edge.
- Latency: out_valid rises 1+4*k edges after the accept edge, where k is the number of iterations run (k=1 gives 5; k=MAX_ITER=8 gives 33).
- flush has highest priority. In any state, flush=1 moves to IDLE on the next edge: enables=0, out_valid=0, in_ready=1, iter_count and converged keep their last values. A flush in DONE discards the result. A flush in IDLE has no effect.
- Simultaneous flush and out_ready in DONE: treated as flush; the stats counters do not count the frame.
- in_valid outside IDLE is ignored; the upstream holds data until in_ready.
- Reset mid-frame: immediate return to reset values; the datapath contents are don't-care.
- No arithmetic beyond iter_count increment. The counter never exceeds MAX_ITER; wrap is impossible by construction.

Optional Feature:
- Macro LDPC_ITER_STATS_EN.
- With the macro: outputs frame_cnt[STAT_W] and fail_cnt[STAT_W], both reset to 0.
  - frame_cnt increments on each out_valid&&out_ready handshake.
  - fail_cnt increments on the same handshake when converged=0.
  - Both saturate at all-ones and are not incremented by flushed frames.
- Without the macro: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package ldpc_pkg holds:
  - the state enum ldpc_ctrl_state_t;
  - localparams N_VARS=10, N_CHECKS and LLR_W=32, shared with the Decoder datapath;
  - default MAX_ITER.
- Sub-module ldpc_sat_counter (width parameter, inc, saturating), instantiated twice under LDPC_ITER_STATS_EN. The FSM stays in the top module.

Test Plan:
- Evidence {-13,13,13,13,-13,13,13,-13,13,-13}, syndrome_ok=1 at first CHK -> one pulse each of ld_en/v2c_en/c2v_en/bel_en; out_valid 5 edges after accept; converged=1; iter_count=1.
- syndrome_ok tied 0 -> 8 iterations of v2c/c2v/bel pulses; out_valid 33 edges after accept; converged=0; iter_count=8.
- syndrome_ok=1 only at third CHK -> out_valid at edge 13; iter_count=3; converged=1; syndrome_ok=1 in non-CHK cycles has no effect.
- out_ready held 0 for 4 cycles in DONE -> out_valid/converged/iter_count stable, in_ready=0, in_valid ignored; in_ready=1 the edge after the handshake.
- flush during C2V of iteration 2 -> IDLE next edge, no out_valid, in_ready=1; next frame decodes normally; stats unchanged.
- rst_n pulsed low during V2C -> all outputs 0 immediately. With LDPC_ITER_STATS_EN: 2 frames (one pass, one fail) -> frame_cnt=2, fail_cnt=1; a forced counter near 0xFFFF stays at 0xFFFF.
